// File: rtl/mcdf_fmt_packer.sv
// mcdf_fmt_packer: formatter stage behind the arbiter's channel selector.
// Pulls one packet (LEN words) from the granted channel into a local buffer,
// requests the outbound formatter bus, and streams the packet with start/end
// framing, channel id and length once the bus is granted.
//
// Optional build macro: MCDF_FMT_PARITY_EN
//   When defined, a running XOR of the loaded words is appended as an extra
//   final word; fmt_end_o marks that parity word and fmt_length_o still
//   reports the data-word count.
//
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   a_req_i/a_id_i       arbiter has a full packet ready on channel a_id_i
//   a_val_i/a_data_i     word of the selected channel; a_ack_o pops it
//   len_sel_i            length code 0..3 -> 4/8/16/32 words
//   fmt_req_o/grant_i    outbound bus request/grant
//   fmt_chid_o/length_o  channel id and data-word count of current packet
//   fmt_start_o/end_o    first/last word framing
//   fmt_data_o           outbound word
//   busy_o               packet in progress
module mcdf_fmt_packer #(
  parameter int unsigned DW      = 32,
  parameter int unsigned MAX_LEN = 32
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          a_req_i,
  input  logic [1:0]    a_id_i,
  input  logic          a_val_i,
  input  logic [DW-1:0] a_data_i,
  output logic          a_ack_o,
  input  logic [1:0]    len_sel_i,
  output logic          fmt_req_o,
  input  logic          fmt_grant_i,
  output logic [1:0]    fmt_chid_o,
  output logic [5:0]    fmt_length_o,
  output logic          fmt_start_o,
  output logic          fmt_end_o,
  output logic [DW-1:0] fmt_data_o,
  output logic          busy_o
);

  localparam int unsigned AW = $clog2(MAX_LEN);

  typedef enum logic [1:0] {StIdle, StLoad, StReq, StSend} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [5:0]    cnt_q, cnt_d, len_q, len_d;
  logic [5:0]    last_idx;
  logic [1:0]    chid_q, chid_d;
  logic          req_q, req_d, start_q, start_d, end_q, end_d;
  logic [DW-1:0] data_q, data_d;
  logic          wr_en;
  logic [DW-1:0] mem_q [MAX_LEN];

`ifdef MCDF_FMT_PARITY_EN
  logic [DW-1:0] par_q, par_d;
  // Parity word occupies index LEN, after the LEN data words.
  assign last_idx = len_q;
`else
  assign last_idx = len_q - 6'd1;
`endif

  assign a_ack_o      = (state_q == StLoad) & a_val_i;
  assign busy_o       = (state_q != StIdle);
  assign fmt_req_o    = req_q;
  assign fmt_chid_o   = chid_q;
  assign fmt_length_o = len_q;
  assign fmt_start_o  = start_q;
  assign fmt_end_o    = end_q;
  assign fmt_data_o   = data_q;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    chid_d  = chid_q;
    req_d   = req_q;
    start_d = 1'b0;
    end_d   = 1'b0;
    data_d  = '0;
    wr_en   = 1'b0;
`ifdef MCDF_FMT_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (a_req_i) begin
          chid_d  = a_id_i;
          len_d   = 6'd4 << len_sel_i;
          wptr_d  = '0;
          rptr_d  = '0;
          cnt_d   = '0;
`ifdef MCDF_FMT_PARITY_EN
          par_d   = '0;
`endif
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (a_val_i) begin
          wr_en  = 1'b1;
          wptr_d = wptr_q + 1'b1;
`ifdef MCDF_FMT_PARITY_EN
          par_d  = par_q ^ a_data_i;
`endif
          if (cnt_q == len_q - 6'd1) begin
            cnt_d   = '0;
            req_d   = 1'b1;
            state_d = StReq;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      StReq: begin
        // Word 0 is registered on the grant edge so it appears next cycle.
        if (fmt_grant_i) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          data_d  = mem_q[rptr_q];
          rptr_d  = rptr_q + 1'b1;
          start_d = 1'b1;
          end_d   = (last_idx == 6'd0);
          state_d = StSend;
        end
      end
      StSend: begin
        // cnt_q is the index of the word currently on fmt_data_o.
        if (cnt_q == last_idx) begin
          state_d = StIdle;
        end else begin
          cnt_d  = cnt_q + 6'd1;
          data_d = mem_q[rptr_q];
          rptr_d = rptr_q + 1'b1;
          end_d  = (cnt_d == last_idx);
`ifdef MCDF_FMT_PARITY_EN
          if (cnt_d == len_q) data_d = par_q;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      chid_q  <= '0;
      req_q   <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      data_q  <= '0;
`ifdef MCDF_FMT_PARITY_EN
      par_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      chid_q  <= chid_d;
      req_q   <= req_d;
      start_q <= start_d;
      end_q   <= end_d;
      data_q  <= data_d;
`ifdef MCDF_FMT_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Packet buffer; contents are only read after being written this packet.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q] <= a_data_i;
  end

endmodule

// File: tb/tb_mcdf_fmt_packer.sv
module tb_mcdf_fmt_packer;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          a_req_i, a_val_i, a_ack_o, fmt_req_o, fmt_grant_i;
  logic          fmt_start_o, fmt_end_o, busy_o;
  logic [1:0]    a_id_i, len_sel_i, fmt_chid_o;
  logic [5:0]    fmt_length_o;
  logic [DW-1:0] a_data_i, fmt_data_o;

  int total = 0;
  int bad   = 0;

  mcdf_fmt_packer #(.DW(DW), .MAX_LEN(32)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .a_req_i(a_req_i), .a_id_i(a_id_i),
    .a_val_i(a_val_i), .a_data_i(a_data_i), .a_ack_o(a_ack_o), .len_sel_i(len_sel_i),
    .fmt_req_o(fmt_req_o), .fmt_grant_i(fmt_grant_i), .fmt_chid_o(fmt_chid_o),
    .fmt_length_o(fmt_length_o), .fmt_start_o(fmt_start_o), .fmt_end_o(fmt_end_o),
    .fmt_data_o(fmt_data_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; a_req_i = 0; a_id_i = 0; a_val_i = 0; a_data_i = 0;
    len_sel_i = 0; fmt_grant_i = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({a_ack_o, fmt_req_o, fmt_chid_o, fmt_length_o, fmt_start_o, fmt_end_o,
           fmt_data_o, busy_o} !== '0)
        begin bad++; $display("FAIL reset_outputs cycle %0d: busy=%b req=%b data=%h", i,
                              busy_o, fmt_req_o, fmt_data_o); end
    end
    rstn_i = 1'b1;
    a_val_i = 1'b1; a_data_i = 32'hdead_beef; fmt_grant_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({a_ack_o, fmt_req_o, fmt_chid_o, fmt_length_o, fmt_start_o, fmt_end_o,
           fmt_data_o, busy_o} !== '0)
        begin bad++; $display("FAIL idle_after_reset cycle %0d: ack=%b busy=%b req=%b", i,
                              a_ack_o, busy_o, fmt_req_o); end
    end
    a_val_i = 1'b0; fmt_grant_i = 1'b0;
  endtask

  // One full packet: IDLE handshake, LOAD, REQ wait, SEND, checked against a queue model.
  // dmode: 0 incrementing from base, 1 random, 2 one-hot (1<<i).
  task automatic run_packet(input logic [1:0] id, input logic [1:0] lsel, input int dmode,
                            input logic [31:0] base, input bit toggle_val, input bit disturb,
                            input int gnt_delay, input int abort_at);
    int len, nout, acks, cyc, exp_cyc;
    logic [31:0] words[$];
    logic [31:0] exp_q[$];
    logic [31:0] par, w;
    len = 4 << lsel;
    par = 0;
    for (int i = 0; i < len; i++) begin
      w = (dmode == 0) ? base + i : (dmode == 1) ? $urandom : (32'd1 << i);
      words.push_back(w);
      par ^= w;
    end
    exp_q = words;
`ifdef MCDF_FMT_PARITY_EN
    exp_q.push_back(par);
`endif
    nout = exp_q.size();

    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL start_idle: busy=%b want 0", busy_o); end
    a_req_i = 1'b1; a_id_i = id; len_sel_i = lsel;
    tick();
    a_req_i = 1'b0;

    acks = 0; cyc = 0;
    exp_cyc = toggle_val ? 2 * len - 1 : len;
    while (acks < len && cyc < 200) begin
      a_val_i  = toggle_val ? (cyc % 2 == 0) : 1'b1;
      a_data_i = a_val_i ? words[acks] : $urandom;
      if (disturb) begin
        a_id_i = 2'd1; len_sel_i = 2'd2; a_req_i = $urandom; fmt_grant_i = (cyc % 2 == 0);
      end
      #1;
      total++;
      if (a_ack_o !== a_val_i)
        begin bad++; $display("FAIL load_ack cycle %0d: ack=%b want %b", cyc, a_ack_o, a_val_i); end
      total++;
      if (fmt_req_o !== 1'b0 || fmt_start_o !== 1'b0 || busy_o !== 1'b1)
        begin bad++; $display("FAIL load_outputs cycle %0d: req=%b start=%b busy=%b want 0 0 1",
                              cyc, fmt_req_o, fmt_start_o, busy_o); end
      if (a_val_i) acks++;
      @(posedge clk_i); #1;
      cyc++;
    end
    a_val_i = 1'b0; a_req_i = 1'b0; fmt_grant_i = 1'b0;
    total++;
    if (cyc != exp_cyc)
      begin bad++; $display("FAIL load_cycles: got %0d want %0d (acks %0d)", cyc, exp_cyc, acks); end

    for (int i = 0; i <= gnt_delay; i++) begin
      a_val_i = 1'b1; a_data_i = $urandom;
      fmt_grant_i = (i == gnt_delay);
      #1;
      total++;
      if (fmt_req_o !== 1'b1 || fmt_start_o !== 1'b0 || a_ack_o !== 1'b0 || busy_o !== 1'b1)
        begin bad++; $display("FAIL req_wait %0d: req=%b start=%b ack=%b busy=%b want 1 0 0 1",
                              i, fmt_req_o, fmt_start_o, a_ack_o, busy_o); end
      @(posedge clk_i); #1;
    end
    fmt_grant_i = 1'b0; a_val_i = 1'b0;

    for (int k = 0; k < nout; k++) begin
      if (k == abort_at) begin
        #2 rstn_i = 1'b0;
        #1;
        total++;
        if ({a_ack_o, fmt_req_o, fmt_chid_o, fmt_length_o, fmt_start_o, fmt_end_o,
             fmt_data_o, busy_o} !== '0)
          begin bad++; $display("FAIL reset_mid_send: busy=%b data=%h start=%b end=%b want 0",
                                busy_o, fmt_data_o, fmt_start_o, fmt_end_o); end
        tick(); tick();
        rstn_i = 1'b1;
        tick();
        total++;
        if (busy_o !== 1'b0 || fmt_data_o !== '0 || fmt_req_o !== 1'b0)
          begin bad++; $display("FAIL post_reset_idle: busy=%b data=%h req=%b want 0",
                                busy_o, fmt_data_o, fmt_req_o); end
        return;
      end
      total++;
      if (fmt_data_o !== exp_q[k])
        begin bad++; $display("FAIL send_data word %0d: got %h want %h", k, fmt_data_o, exp_q[k]); end
      total++;
      if (fmt_start_o !== (k == 0) || fmt_end_o !== (k == nout - 1))
        begin bad++; $display("FAIL send_frame word %0d: start=%b end=%b want %b %b", k,
                              fmt_start_o, fmt_end_o, k == 0, k == nout - 1); end
      total++;
      if (fmt_chid_o !== id || fmt_length_o !== 6'(len) || fmt_req_o !== 1'b0 || busy_o !== 1'b1)
        begin bad++; $display("FAIL send_hdr word %0d: chid=%0d len=%0d req=%b busy=%b want %0d %0d 0 1",
                              k, fmt_chid_o, fmt_length_o, fmt_req_o, busy_o, id, len); end
      tick();
    end
    total++;
    if (fmt_data_o !== '0 || fmt_start_o !== 1'b0 || fmt_end_o !== 1'b0 || busy_o !== 1'b0)
      begin bad++; $display("FAIL send_done: data=%h start=%b end=%b busy=%b want 0",
                            fmt_data_o, fmt_start_o, fmt_end_o, busy_o); end
    total++;
    if (fmt_chid_o !== id || fmt_length_o !== 6'(len))
      begin bad++; $display("FAIL hdr_hold: chid=%0d len=%0d want %0d %0d", fmt_chid_o,
                            fmt_length_o, id, len); end
  endtask

  task automatic test_basic();
    run_packet(2'd2, 2'd0, 0, 32'h10, 1'b0, 1'b0, 3, -1);
  endtask

  task automatic test_long_toggle();
    run_packet(2'($urandom_range(0, 2)), 2'd3, 1, 0, 1'b1, 1'b0, 1, -1);
  endtask

  task automatic test_latch_disturb();
    run_packet(2'd0, 2'd0, 1, 0, 1'b0, 1'b1, 2, -1);
  endtask

  task automatic test_reset_mid_send();
    run_packet(2'd1, 2'd1, 0, 32'h100, 1'b0, 1'b0, 0, 5);
    run_packet(2'd2, 2'd1, 1, 0, 1'b0, 1'b0, 0, -1);
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 6; p++)
      run_packet(2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), 1, 0,
                 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 4), -1);
  endtask

`ifdef MCDF_FMT_PARITY_EN
  task automatic test_parity();
    run_packet(2'd0, 2'd0, 2, 0, 1'b0, 1'b0, 1, -1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_long_toggle();
    test_latch_disturb();
    test_reset_mid_send();
    test_back_to_back();
`ifdef MCDF_FMT_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
